// File: rtl/mips_pkg.sv
// mips_pkg: shared architectural constants for the decode/issue slice.
//   REG_ADDR_W : width of a register specifier
//   NUM_REGS   : number of architectural integer registers (r0 hard-wired to 0)
//   reg_addr_t : register specifier type
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// sb_counter: one per-register pending-writer counter for the hazard scoreboard.
// The counter saturates at both ends. An out-of-range update is flagged on err_o
// in the same cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   inc_i      : an instruction writing this register issues this cycle
//   retire_i   : write-back of this register this cycle
//   kill_i     : a squashed in-flight writer of this register this cycle
//   pend_o     : counter is nonzero (registered state)
//   busy_o     : counter remains nonzero after this cycle's retire/kill
//   err_o      : this cycle's update underflows or overflows (combinational)
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic retire_i,
  input  logic kill_i,
  output logic pend_o,
  output logic busy_o,
  output logic err_o
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   add_s;
  logic [CNT_W:0]   sub_s;
  logic [CNT_W:0]   diff_s;

  // Next-count computation with clamping at 0 and at the maximum value.
  always_comb begin
    add_s  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc_i};
    sub_s  = {{CNT_W{1'b0}}, retire_i} + {{CNT_W{1'b0}}, kill_i};
    diff_s = {(CNT_W+1){1'b0}};
    cnt_d  = cnt_q;
    err_o  = 1'b0;
    // Hazard view ignores this cycle's issue: the retiring value is written on negedge.
    busy_o = ({1'b0, cnt_q} > sub_s);
    if (add_s < sub_s) begin
      cnt_d = {CNT_W{1'b0}};
      err_o = 1'b1;
    end else begin
      diff_s = add_s - sub_s;
      if (diff_s > CNT_MAX) begin
        cnt_d = {CNT_W{1'b1}};
        err_o = 1'b1;
      end else begin
        cnt_d = diff_s[CNT_W-1:0];
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pend_o = (cnt_q != {CNT_W{1'b0}});

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-hazard scoreboard in the ID stage.
// It keeps a count of in-flight writers for each register r1..r31. The decoding
// instruction stalls while any source it reads still has an outstanding writer.
// Write-back in the current cycle clears the hazard in that same cycle, because
// the register file writes on negedge.
// Optional feature: define REG_SCOREBOARD_STALL_CNT_EN to add the stall_cycles
// output, a 32-bit wrapping count of stalled posedges.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   id_valid                  : decode slot holds a valid instruction
//   id_src1/2, id_use_src1/2  : source registers and their read enables
//   id_wb_en, id_dest         : instruction writes id_dest
//   wb_en, wb_dest            : write-back this cycle
//   cancel_en, cancel_dest    : squash of an issued, unretired writer
//   stall                     : combinational stall of PC/IF-ID, bubble into ID/EX
//   pending                   : bit r = register r has outstanding writers (bit 0 = 0)
//   err                       : sticky counter overflow/underflow flag
//   stall_cycles              : (optional) stalled-cycle count
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  cancel_en,
  input  logic [REG_ADDR_W-1:0] cancel_dest,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  err
`ifdef REG_SCOREBOARD_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic [NUM_REGS-1:0] pend_s;
  logic [NUM_REGS-1:0] busy_s;
  logic [NUM_REGS-1:0] err_evt_s;
  logic                hazard1_s;
  logic                hazard2_s;
  logic                issue_s;
  logic                err_q;

  // r0 never has a writer in flight.
  assign pend_s[0]    = 1'b0;
  assign busy_s[0]    = 1'b0;
  assign err_evt_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic inc_s;
    logic retire_s;
    logic kill_s;

    assign inc_s    = issue_s   & (id_dest     == REG_ADDR_W'(r));
    assign retire_s = wb_en     & (wb_dest     == REG_ADDR_W'(r));
    assign kill_s   = cancel_en & (cancel_dest == REG_ADDR_W'(r));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (inc_s),
      .retire_i (retire_s),
      .kill_i   (kill_s),
      .pend_o   (pend_s[r]),
      .busy_o   (busy_s[r]),
      .err_o    (err_evt_s[r])
    );
  end

  // Decode-stage hazard detection and issue qualification.
  always_comb begin
    hazard1_s = id_use_src1 & (id_src1 != {REG_ADDR_W{1'b0}}) & busy_s[id_src1];
    hazard2_s = id_use_src2 & (id_src2 != {REG_ADDR_W{1'b0}}) & busy_s[id_src2];
    stall     = id_valid & (hazard1_s | hazard2_s);
    // A stalled instruction's destination is not counted until it actually issues.
    issue_s   = id_valid & ~stall & id_wb_en & (id_dest != {REG_ADDR_W{1'b0}});
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (|err_evt_s);
    end
  end

  assign err     = err_q;
  assign pending = pend_s;

`ifdef REG_SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cycles_q;

  // Count stalled cycles; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
    end else if (stall) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard in the ID stage, directly upstream of the register file read ports. It tracks, per architectural register, how many in-flight instructions will still write it. It stalls the decoding instruction until every source it reads has been written back. Write-back updates the counts in the same cycle that the register file performs its negedge write, so a value retiring this cycle can be read by the stalled instruction without an extra bubble.

## Interface
- CNT_W, 2: width of each per-register pending counter; maximum in-flight writers per register is 2^CNT_W-1.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode slot holds a valid instruction.
- id_src1, id_src2  in  5 each  source register numbers.
- id_use_src1, id_use_src2  in  1 each  instruction actually reads that source.
- id_wb_en  in  1  instruction will write a register.
- id_dest  in  5  destination register.
- wb_en  in  1  write-back stage writes this cycle (same signal that drives the register file write enable).
- wb_dest  in  5  write-back destination.
- cancel_en  in  1  an issued, not-yet-retired instruction is squashed (branch flush).
- cancel_dest  in  5  destination of the squashed instruction.
- stall  out  1  combinational; holds PC and IF/ID and injects a bubble into ID/EX.
- pending  out  32  bit r = counter r nonzero (registered view); bit 0 is always 0.
- err  out  1  sticky; set on counter overflow or underflow.

## Operation
- State: 31 counters cnt[1..31], CNT_W bits each. Register 0 has no counter and is never pending.
- retire_r = wb_en & wb_dest==r & r!=0.
- kill_r = cancel_en & cancel_dest==r & r!=0.
- eff_r = cnt[r] - retire_r - kill_r, saturating at 0.
- hazard_k = id_use_srck & id_srck!=0 & eff[id_srck]!=0.
- stall = id_valid & (hazard_1 | hazard_2).
- issue = id_valid & ~stall & id_wb_en & id_dest!=0.
- Next cnt[r] = cnt[r] + (issue & id_dest==r) - retire_r - kill_r. All three terms may hit the same r in one cycle; the net delta ranges from -2 to +1.
- Underflow (net result < 0): counter is clamped to 0 and err is set.
- Overflow (result > 2^CNT_W-1): counter holds its maximum and err is set.
- err clears only on rst.
- A stalled instruction never issues. Its dest is not counted until the cycle in which stall is 0.

## Timing
- Reset values: all counters 0, pending=0, err=0, stall=0 (no counters are set, so stall cannot assert), stall_cycles=0.
- stall is combinational from the current counters plus same-cycle wb/cancel. It has zero latency.
- An issue at posedge N is visible in pending and hazard checks from cycle N+1.
- A retire in cycle N clears the hazard in cycle N itself, because the register file writes on negedge.
- rst asserted mid-operation clears all counters immediately. The pipeline flush is the caller's responsibility.

## Configuration
- REG_SCOREBOARD_STALL_CNT_EN defined: adds output stall_cycles (32 bits).
  - Increments on every posedge where stall=1.
  - Wraps at 2^32.
  - Reset to 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package mips_pkg: REG_ADDR_W=5, NUM_REGS=32, and the reg_addr_t typedef.
- Sub-module sb_counter holds one saturating up/down counter with its err contribution. It is instantiated 31 times via generate.
- The top level contains the decode compare, stall logic, err OR-reduction, and the optional stall counter.

## Test plan
- **Reset:** after rst pulse → pending=0, err=0, stall=0, and id_valid with any sources gives stall=0.
- **Write then read:** issue dest=5, then the next cycle src1=5, use_src1=1 → stall=1, and it stays 1 until wb_en with wb_dest=5. In that wb cycle stall=0 and pending[5] drops the next cycle.
- **Same-cycle issue and retire:** cnt[7]=1; issue dest=7 while wb_dest=7 → cnt[7] stays 1, pending[7]=1, and a same-cycle read of 7 does not stall.
- **Register 0:** issue dest=0 and read src=0 → never stalls, and pending[0]=0.
- **Cancel and underflow:** issue dest=9, then cancel_dest=9 → pending[9]=0 with err=0. A second cancel_dest=9 → err=1 and cnt stays 0.
- **Overflow and stall count:** issue dest=3 four times with no retire (CNT_W=2) → err=1 and cnt[3]=3. With REG_SCOREBOARD_STALL_CNT_EN, 10 stalled cycles → stall_cycles=10.
